// File: rtl/sram_arbiter_pkg.sv
// Shared op codes, FSM states and helpers for the SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'b0000,
    MEM_LW  = 4'b0001,
    MEM_LH  = 4'b0010,
    MEM_LHU = 4'b0011,
    MEM_LB  = 4'b0100,
    MEM_LBU = 4'b0101,
    MEM_SW  = 4'b0110,
    MEM_SH  = 4'b0111,
    MEM_SB  = 4'b1000
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE_IF  = 2'd1,
    ST_SERVE_MEM = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

  function automatic logic op_is_load(input mem_op_e op);
    return op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
  endfunction

endpackage

// File: rtl/sram_arbiter_timer.sv
// Wait counter for a granted SRAM access; flags expiry at TIMEOUT_CYCLES-1.
module sram_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk50,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single SRAM controller,
// with data priority bounded by a burst limit and a per-access timeout.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [19:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic [3:0]  mem_op_i,
  input  logic [19:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [19:0] ramAddr_o,
  output logic [31:0] storeData_o,
  output logic [3:0]  ramOp_o,
  input  logic [31:0] loadData_i,
  input  logic        success_i
);

  localparam int unsigned BW = $clog2(DATA_BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  mem_op_e       ram_op_q, ram_op_d;
  logic [19:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   store_data_q, store_data_d;
  logic [31:0]   if_data_q, if_data_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic          err_q, err_d;
  logic [BW-1:0] burst_q, burst_d;

  logic timer_clr, timer_en, timer_expired;
  logic mem_valid, fetch_wins;

  sram_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk50    (clk50),
    .rst      (rst),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  assign mem_valid  = mem_req_i && (mem_op_i != MEM_NOP);
  // Data normally wins; a pending fetch takes over once the burst limit is reached.
  assign fetch_wins = if_req_i && (!mem_valid || (burst_q == BW'(DATA_BURST_MAX)));

  always_comb begin
    state_d      = state_q;
    ram_op_d     = ram_op_q;
    ram_addr_d   = ram_addr_q;
    store_data_d = store_data_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    err_d        = 1'b0;
    burst_d      = burst_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_wins) begin
          state_d      = ST_SERVE_IF;
          ram_op_d     = MEM_LW;
          ram_addr_d   = if_addr_i;
          store_data_d = '0;
          burst_d      = '0;
          timer_clr    = 1'b1;
        end else if (mem_valid) begin
          state_d      = ST_SERVE_MEM;
          ram_op_d     = mem_op_e'(mem_op_i);
          ram_addr_d   = mem_addr_i;
          store_data_d = mem_wdata_i;
          timer_clr    = 1'b1;
          if (!if_req_i)                            burst_d = '0;
          else if (burst_q != BW'(DATA_BURST_MAX))  burst_d = burst_q + BW'(1);
        end else if (!if_req_i) begin
          burst_d = '0;
        end
      end
      ST_SERVE_IF, ST_SERVE_MEM: begin
        timer_en = 1'b1;
        // Success takes precedence over a simultaneous timeout.
        if (success_i || timer_expired) begin
          state_d  = ST_RELEASE;
          ram_op_d = MEM_NOP;
          err_d    = !success_i;
          if (state_q == ST_SERVE_IF) begin
            if_ack_d  = 1'b1;
            if_data_d = success_i ? loadData_i : '0;
          end else begin
            mem_ack_d = 1'b1;
            if (!success_i)                mem_rdata_d = '0;
            else if (op_is_load(ram_op_q)) mem_rdata_d = loadData_i;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ram_op_q     <= MEM_NOP;
      ram_addr_q   <= '0;
      store_data_q <= '0;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      err_q        <= 1'b0;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      ram_op_q     <= ram_op_d;
      ram_addr_q   <= ram_addr_d;
      store_data_q <= store_data_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      err_q        <= err_d;
      burst_q      <= burst_d;
    end
  end

  assign ramOp_o     = ram_op_q;
  assign ramAddr_o   = ram_addr_q;
  assign storeData_o = store_data_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (mem_valid & ~mem_ack_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, conflict, starvation, timeout and reset cases.
module tb_sram_arbiter;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_SW  = 4'd6;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [19:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic [3:0]  mem_op_i;
  logic [19:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        err_o;
  logic        stall_o;
  logic [19:0] ramAddr_o;
  logic [31:0] storeData_o;
  logic [3:0]  ramOp_o;
  logic [31:0] loadData_i;
  logic        success_i;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #10 clk50 = ~clk50;

  sram_arbiter #(.TIMEOUT_CYCLES(16), .DATA_BURST_MAX(4)) dut (
    .clk50      (clk50),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ack_o   (if_ack_o),
    .mem_req_i  (mem_req_i),
    .mem_op_i   (mem_op_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ack_o  (mem_ack_o),
    .err_o      (err_o),
    .stall_o    (stall_o),
    .ramAddr_o  (ramAddr_o),
    .storeData_o(storeData_o),
    .ramOp_o    (ramOp_o),
    .loadData_i (loadData_i),
    .success_i  (success_i)
  );

  task automatic test_reset();
    rst = 1'b0; if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_op_i = OP_NOP;
    mem_addr_i = '0; mem_wdata_i = '0; loadData_i = '0; success_i = 0;
    @(negedge clk50); @(negedge clk50);
    total++; if (ramOp_o !== OP_NOP) $display("FAIL reset_op got=%h exp=%h", ramOp_o, OP_NOP); else passed++;
    total++; if (ramAddr_o !== 20'h0) $display("FAIL reset_addr got=%h exp=0", ramAddr_o); else passed++;
    total++; if (storeData_o !== 32'h0) $display("FAIL reset_sdata got=%h exp=0", storeData_o); else passed++;
    total++; if ({if_ack_o, mem_ack_o, err_o} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {if_ack_o, mem_ack_o, err_o}); else passed++;
    total++; if ({if_data_o, mem_rdata_o} !== 64'h0) $display("FAIL reset_data got=%h exp=0", {if_data_o, mem_rdata_o}); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk50); if_req_i = 1; if_addr_i = 20'h00010;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_LW) $display("FAIL fetch_op0 got=%h exp=%h", ramOp_o, OP_LW); else passed++;
    total++; if (ramAddr_o !== 20'h00010) $display("FAIL fetch_addr got=%h exp=00010", ramAddr_o); else passed++;
    total++; if (storeData_o !== 32'h0) $display("FAIL fetch_sdata got=%h exp=0", storeData_o); else passed++;
    total++; if (stall_o !== 1'b1) $display("FAIL fetch_stall got=%b exp=1", stall_o); else passed++;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_LW) $display("FAIL fetch_op1 got=%h exp=%h", ramOp_o, OP_LW); else passed++;
    total++; if (if_ack_o !== 1'b0) $display("FAIL fetch_early_ack got=%b exp=0", if_ack_o); else passed++;
    success_i = 1; loadData_i = 32'hDEADBEEF;
    @(negedge clk50);
    total++; if (if_ack_o !== 1'b1) $display("FAIL fetch_ack got=%b exp=1", if_ack_o); else passed++;
    total++; if (if_data_o !== 32'hDEADBEEF) $display("FAIL fetch_data got=%h exp=deadbeef", if_data_o); else passed++;
    total++; if ({ramOp_o, err_o, mem_ack_o, stall_o} !== 7'b0) $display("FAIL fetch_release got=%b exp=0", {ramOp_o, err_o, mem_ack_o, stall_o}); else passed++;
    if_req_i = 0; success_i = 0;
    @(negedge clk50);
    total++; if ({if_ack_o, ramOp_o} !== 5'b0) $display("FAIL fetch_idle got=%b exp=0", {if_ack_o, ramOp_o}); else passed++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk50);
    if_req_i = 1; if_addr_i = 20'h00040;
    mem_req_i = 1; mem_op_i = OP_SW; mem_addr_i = 20'h00020; mem_wdata_i = 32'h12345678;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_SW) $display("FAIL simul_op_sw got=%h exp=%h", ramOp_o, OP_SW); else passed++;
    total++; if (ramAddr_o !== 20'h00020) $display("FAIL simul_addr_sw got=%h exp=00020", ramAddr_o); else passed++;
    total++; if (storeData_o !== 32'h12345678) $display("FAIL simul_sdata got=%h exp=12345678", storeData_o); else passed++;
    success_i = 1; loadData_i = 32'hAAAA5555;
    @(negedge clk50);
    total++; if ({mem_ack_o, if_ack_o, err_o} !== 3'b100) $display("FAIL simul_mem_ack got=%b exp=100", {mem_ack_o, if_ack_o, err_o}); else passed++;
    total++; if (mem_rdata_o !== 32'h0) $display("FAIL simul_store_rdata got=%h exp=0", mem_rdata_o); else passed++;
    mem_req_i = 0; mem_op_i = OP_NOP; success_i = 0;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_NOP) $display("FAIL simul_gap got=%h exp=%h", ramOp_o, OP_NOP); else passed++;
    @(negedge clk50);
    total++; if ({ramOp_o, ramAddr_o} !== {OP_LW, 20'h00040}) $display("FAIL simul_fetch got=%h/%h exp=1/00040", ramOp_o, ramAddr_o); else passed++;
    total++; if (storeData_o !== 32'h0) $display("FAIL simul_fetch_sdata got=%h exp=0", storeData_o); else passed++;
    success_i = 1; loadData_i = 32'hCAFEF00D;
    @(negedge clk50);
    total++; if ({if_ack_o, mem_ack_o} !== 2'b10) $display("FAIL simul_if_ack got=%b exp=10", {if_ack_o, mem_ack_o}); else passed++;
    total++; if (if_data_o !== 32'hCAFEF00D) $display("FAIL simul_if_data got=%h exp=cafef00d", if_data_o); else passed++;
    if_req_i = 0; success_i = 0;
    @(negedge clk50);
  endtask

  task automatic test_starvation();
    int unsigned grants = 0;
    int unsigned cyc = 0;
    logic [19:0] exp_addr;
    @(negedge clk50);
    if_req_i = 1; if_addr_i = 20'h00080;
    mem_req_i = 1; mem_op_i = OP_LW; mem_addr_i = 20'h00100;
    success_i = 1; loadData_i = 32'h11112222;
    while (grants < 10 && cyc < 100) begin
      @(negedge clk50);
      cyc++;
      if (ramOp_o !== OP_NOP) begin
        exp_addr = (grants % 5 == 4) ? 20'h00080 : 20'h00100;
        total++; if (ramAddr_o !== exp_addr) $display("FAIL starve_grant%0d got=%h exp=%h", grants, ramAddr_o, exp_addr); else passed++;
        grants++;
      end
    end
    if (grants < 10) begin
      total++;
      $display("FAIL starve_budget got=%0d grants exp=10", grants);
    end
    @(negedge clk50);
    if_req_i = 0; mem_req_i = 0; mem_op_i = OP_NOP; success_i = 0;
    @(negedge clk50); @(negedge clk50);
    total++; if (mem_rdata_o !== 32'h11112222) $display("FAIL starve_rdata got=%h exp=11112222", mem_rdata_o); else passed++;
  endtask

  task automatic test_timeout();
    @(negedge clk50);
    mem_req_i = 1; mem_op_i = OP_LW; mem_addr_i = 20'h00200; success_i = 0; loadData_i = 32'h55AA55AA;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_LW) $display("FAIL tmo_op0 got=%h exp=%h", ramOp_o, OP_LW); else passed++;
    repeat (15) @(negedge clk50);
    total++; if ({ramOp_o, mem_ack_o} !== {OP_LW, 1'b0}) $display("FAIL tmo_cycle15 got=%b exp=00010", {ramOp_o, mem_ack_o}); else passed++;
    @(negedge clk50);
    total++; if ({mem_ack_o, err_o, if_ack_o} !== 3'b110) $display("FAIL tmo_ack_err got=%b exp=110", {mem_ack_o, err_o, if_ack_o}); else passed++;
    total++; if (mem_rdata_o !== 32'h0) $display("FAIL tmo_data got=%h exp=0", mem_rdata_o); else passed++;
    total++; if (ramOp_o !== OP_NOP) $display("FAIL tmo_release_op got=%h exp=0", ramOp_o); else passed++;
    mem_req_i = 0; mem_op_i = OP_NOP;
    @(negedge clk50);
    total++; if ({mem_ack_o, err_o, ramOp_o} !== 6'b0) $display("FAIL tmo_idle got=%b exp=0", {mem_ack_o, err_o, ramOp_o}); else passed++;
  endtask

  task automatic test_timeout_tie();
    @(negedge clk50);
    mem_req_i = 1; mem_op_i = OP_LW; mem_addr_i = 20'h00240; success_i = 0;
    @(negedge clk50);
    repeat (15) @(negedge clk50);
    success_i = 1; loadData_i = 32'h0BADCAFE;
    @(negedge clk50);
    total++; if ({mem_ack_o, err_o} !== 2'b10) $display("FAIL tie_ack_err got=%b exp=10", {mem_ack_o, err_o}); else passed++;
    total++; if (mem_rdata_o !== 32'h0BADCAFE) $display("FAIL tie_data got=%h exp=0badcafe", mem_rdata_o); else passed++;
    mem_req_i = 0; mem_op_i = OP_NOP; success_i = 0;
    @(negedge clk50);
  endtask

  task automatic test_reset_mid();
    @(negedge clk50);
    mem_req_i = 1; mem_op_i = OP_SW; mem_addr_i = 20'h00300; mem_wdata_i = 32'hA5A5A5A5;
    @(negedge clk50);
    total++; if (ramOp_o !== OP_SW) $display("FAIL rmid_serve got=%h exp=%h", ramOp_o, OP_SW); else passed++;
    #3 rst = 1'b0;
    #1;
    total++; if (ramOp_o !== OP_NOP) $display("FAIL rmid_async_op got=%h exp=0", ramOp_o); else passed++;
    total++; if ({ramAddr_o, storeData_o} !== 52'h0) $display("FAIL rmid_async_bus got=%h exp=0", {ramAddr_o, storeData_o}); else passed++;
    success_i = 1;
    @(negedge clk50);
    total++; if ({mem_ack_o, if_ack_o} !== 2'b00) $display("FAIL rmid_no_ack got=%b exp=00", {mem_ack_o, if_ack_o}); else passed++;
    success_i = 0; rst = 1'b1;
    @(negedge clk50);
    total++; if ({ramOp_o, ramAddr_o, storeData_o} !== {OP_SW, 20'h00300, 32'hA5A5A5A5}) $display("FAIL rmid_regrant got=%h/%h/%h exp=6/00300/a5a5a5a5", ramOp_o, ramAddr_o, storeData_o); else passed++;
    success_i = 1;
    @(negedge clk50);
    total++; if ({mem_ack_o, err_o} !== 2'b10) $display("FAIL rmid_ack got=%b exp=10", {mem_ack_o, err_o}); else passed++;
    mem_req_i = 0; mem_op_i = OP_NOP; success_i = 0;
    @(negedge clk50);
  endtask

  task automatic test_nop_req();
    @(negedge clk50);
    mem_req_i = 1; mem_op_i = OP_NOP; mem_addr_i = 20'h00400; success_i = 1; loadData_i = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk50);
      total++; if ({stall_o, ramOp_o, mem_ack_o, if_ack_o} !== 7'b0) $display("FAIL nop_req%0d got=%b exp=0", i, {stall_o, ramOp_o, mem_ack_o, if_ack_o}); else passed++;
    end
    mem_req_i = 0; success_i = 0;
    @(negedge clk50);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    test_nop_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
